// File: rtl/memory_pkg.sv
// Shared sizing constants for the word-addressed memory block.
package memory_pkg;

  localparam int MEM_DATA_WIDTH = 32;
  localparam int MEM_ADDR_WIDTH = 32;
  localparam int MEM_DEPTH      = 256;
  localparam int MEM_IDX_WIDTH  = $clog2(MEM_DEPTH);

endpackage : memory_pkg

// File: rtl/memory.sv
// Word-addressed register-array memory: single-cycle writes, registered reads (latency 1),
// write-first on simultaneous read+write, no handshake so no backpressure.
module memory
  import memory_pkg::*;
#(
  parameter int DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int DEPTH      = MEM_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  MemRd,
  input  logic                  MemWr,
  input  logic                  MemEnable,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_out_q;
  logic [DATA_WIDTH-1:0] data_out_d;
  logic [IDX_W-1:0]      idx;
  logic                  in_range;
  logic                  wr_en;
  logic                  rd_en;

  assign idx = address[IDX_W-1:0];

  // Any set bit above the index field means the word does not exist.
  generate
    if (ADDR_WIDTH > IDX_W) begin : g_range
      assign in_range = (address[ADDR_WIDTH-1:IDX_W] == '0);
    end else begin : g_full
      assign in_range = 1'b1;
    end
  endgenerate

  assign wr_en = MemEnable & MemWr & in_range;
  assign rd_en = MemEnable & MemRd;

  always_comb begin
    data_out_d = data_out_q;
    if (rd_en) begin
      if (!in_range) begin
        data_out_d = '0;
      end else if (MemWr) begin
        data_out_d = data_in;
      end else begin
        data_out_d = mem_q[idx];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[idx] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule : memory

// File: tb/tb_memory.sv
// Self-checking bench for memory: directed scenarios plus randomized traffic against an array model.
module tb_memory;

  logic        clk;
  logic        reset;
  logic [31:0] address;
  logic [31:0] data_in;
  logic        MemRd;
  logic        MemWr;
  logic        MemEnable;
  logic [31:0] data_out;

  int n_checks;
  int n_pass;

  logic [31:0] ref_mem [256];
  logic [31:0] ref_out;

  memory dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .data_in   (data_in),
    .MemRd     (MemRd),
    .MemWr     (MemWr),
    .MemEnable (MemEnable),
    .data_out  (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    ref_out = 32'h0;
  endtask

  // Behavioural view of one rising edge.
  task automatic model_edge(input logic en, input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [31:0] din);
    bit ok;
    ok = (addr < 32'd256);
    if (reset) begin
      model_clear();
    end else if (en) begin
      if (wr && ok) ref_mem[addr[7:0]] = din;
      if (rd) ref_out = ok ? ref_mem[addr[7:0]] : 32'h0;
    end
  endtask

  task automatic access(input string tag, input logic en, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] din);
    @(negedge clk);
    MemEnable = en;
    MemRd     = rd;
    MemWr     = wr;
    address   = addr;
    data_in   = din;
    @(posedge clk);
    model_edge(en, rd, wr, addr, din);
    #1;
    check(tag, data_out, ref_out);
  endtask

  task automatic idle(input string tag);
    access(tag, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    n_checks  = 0;
    n_pass    = 0;
    reset     = 1'b1;
    address   = 32'h0;
    data_in   = 32'h0;
    MemRd     = 1'b0;
    MemWr     = 1'b0;
    MemEnable = 1'b0;
    model_clear();

    repeat (2) @(negedge clk);
    check("reset_out", data_out, 32'h0);
    reset = 1'b0;

    access("rd0_after_reset", 1, 1, 0, 32'd0, 32'h0);
    check("rd0_const", data_out, 32'h00000000);

    access("wr0", 1, 0, 1, 32'd0, 32'h12345678);
    idle("idle_hold");
    access("rd0", 1, 1, 0, 32'd0, 32'h0);
    check("rd0_const", data_out, 32'h12345678);
    idle("rd_fall_hold");
    check("rd_fall_const", data_out, 32'h12345678);

    access("wr255", 1, 0, 1, 32'd255, 32'hAAAA5555);
    access("wr1", 1, 0, 1, 32'd1, 32'h0000FFFF);
    access("rd255", 1, 1, 0, 32'd255, 32'h0);
    check("rd255_const", data_out, 32'hAAAA5555);
    access("rd1", 1, 1, 0, 32'd1, 32'h0);
    check("rd1_const", data_out, 32'h0000FFFF);

    access("wr_first", 1, 1, 1, 32'd3, 32'hDEADBEEF);
    check("wr_first_const", data_out, 32'hDEADBEEF);
    idle("idle_a");
    access("rd3", 1, 1, 0, 32'd3, 32'h0);
    check("rd3_const", data_out, 32'hDEADBEEF);

    access("wr_disabled", 0, 0, 1, 32'd4, 32'h11111111);
    access("rd_disabled_blocks", 0, 1, 0, 32'd255, 32'h0);
    access("rd4", 1, 1, 0, 32'd4, 32'h0);
    check("rd4_const", data_out, 32'h00000000);
    access("rd1_again", 1, 1, 0, 32'd1, 32'h0);
    access("rd_oor", 1, 1, 0, 32'h100, 32'h0);
    check("rd_oor_const", data_out, 32'h00000000);
    access("wr_oor", 1, 0, 1, 32'h104, 32'h55AA55AA);
    access("rd4_after_oor", 1, 1, 0, 32'd4, 32'h0);

    // Reset asserted between edges right after a nonzero read.
    access("wr0_b", 1, 0, 1, 32'd0, 32'h12345678);
    access("rd0_b", 1, 1, 0, 32'd0, 32'h0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    check("async_reset_out", data_out, 32'h0);
    access("wr_in_reset", 1, 0, 1, 32'd0, 32'hCAFEF00D);
    access("rd_in_reset", 1, 1, 0, 32'd0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    access("rd0_post_reset", 1, 1, 0, 32'd0, 32'h0);
    check("rd0_post_reset_const", data_out, 32'h00000000);
    access("rd255_post_reset", 1, 1, 0, 32'd255, 32'h0);

    // Randomized traffic; a small address window raises the read-after-write hit rate.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else if ($urandom_range(0, 1) == 0) a = $urandom_range(0, 15);
      else a = $urandom_range(0, 255);
      d = $urandom;
      access("rand", ($urandom_range(0, 5) != 0), $urandom_range(0, 1) == 1,
             $urandom_range(0, 2) == 0, a, d);
    end

    for (int i = 0; i < 256; i++) begin
      access("sweep", 1, 1, 0, i, 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_memory
